// File: rtl/fifo_pkg.sv
// Shared constants and types for the 128-bit synchronous FIFO.
package fifo_pkg;

   localparam int unsigned DATA_W         = 128;
   localparam int unsigned DEPTH          = 16;
   localparam int unsigned AF_THR_DEFAULT = DEPTH - 2;
   localparam int unsigned AE_THR_DEFAULT = 2;
   localparam int unsigned PTR_W          = $clog2(DEPTH);
   localparam int unsigned CNT_W          = PTR_W + 1;

   typedef struct packed {
      logic full;
      logic alm_full;
      logic empty;
      logic alm_empty;
   } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_128_if.sv
// FIFO request/data/status bundle; master drives requests, slave is the FIFO.
interface sync_fifo_128_if #(
   parameter int unsigned DATA_W = fifo_pkg::DATA_W
) ();

   logic              i_wren;
   logic              i_rden;
   logic [DATA_W-1:0] i_wrdata;
   logic [DATA_W-1:0] o_rddata;
   logic              o_full;
   logic              o_alm_full;
   logic              o_empty;
   logic              o_alm_empty;

   modport master (
      output i_wren, i_rden, i_wrdata,
      input  o_rddata, o_full, o_alm_full, o_empty, o_alm_empty
   );

   modport slave (
      input  i_wren, i_rden, i_wrdata,
      output o_rddata, o_full, o_alm_full, o_empty, o_alm_empty
   );

endinterface

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage: synchronous write, registered synchronous read.
module fifo_mem_2p #(
   parameter int unsigned DATA_W = fifo_pkg::DATA_W,
   parameter int unsigned DEPTH  = fifo_pkg::DEPTH,
   localparam int unsigned AddrW = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [AddrW-1:0]  wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [AddrW-1:0]  rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Array is deliberately left without reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_128.sv
// Synchronous FIFO: pointers, occupancy counter and status flags around fifo_mem_2p.
module sync_fifo_128 #(
   parameter int unsigned DATA_W = fifo_pkg::DATA_W,
   parameter int unsigned DEPTH  = fifo_pkg::DEPTH,
   parameter int unsigned AF_THR = DEPTH - 2,
   parameter int unsigned AE_THR = fifo_pkg::AE_THR_DEFAULT
) (
   input logic            clk,
   input logic            reset,
   sync_fifo_128_if.slave bus
);

   import fifo_pkg::*;

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              wr_acc, rd_acc;
   logic [DATA_W-1:0] rd_data;
   fifo_flags_t       flags;

   // Flags depend only on registered occupancy, never on this cycle's requests.
   always_comb begin
      flags           = '0;
      flags.full      = (cnt_q == CntW'(DEPTH));
      flags.alm_full  = (cnt_q >= CntW'(AF_THR));
      flags.empty     = (cnt_q == '0);
      flags.alm_empty = (cnt_q <= CntW'(AE_THR));
   end

   assign wr_acc = bus.i_wren & ~flags.full & ~reset;
   assign rd_acc = bus.i_rden & ~flags.empty & ~reset;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({wr_acc, rd_acc})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   fifo_mem_2p #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk_i     (clk),
      .rst_i     (reset),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (bus.i_wrdata),
      .rd_en_i   (rd_acc),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

   assign bus.o_rddata    = rd_data;
   assign bus.o_full      = flags.full;
   assign bus.o_alm_full  = flags.alm_full;
   assign bus.o_empty     = flags.empty;
   assign bus.o_alm_empty = flags.alm_empty;

endmodule

// File: tb/tb_sync_fifo_128.sv
// Directed bench for sync_fifo_128 with a read-data scoreboard and flag checks.
module tb_sync_fifo_128;

   localparam int unsigned DW  = 128;
   localparam int unsigned DEP = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   sync_fifo_128_if #(.DATA_W(DW)) bus ();

   sync_fifo_128 #(
      .DATA_W (DW),
      .DEPTH  (DEP),
      .AF_THR (14),
      .AE_THR (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [DW-1:0] model_q [$];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] last_rd = '0;
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_flags();
      int n;
      n = model_q.size();
      chk("o_full",      DW'(bus.o_full),      DW'(n == 16));
      chk("o_alm_full",  DW'(bus.o_alm_full),  DW'(n >= 14));
      chk("o_empty",     DW'(bus.o_empty),     DW'(n == 0));
      chk("o_alm_empty", DW'(bus.o_alm_empty), DW'(n <= 2));
   endtask

   // One clock of stimulus; the model decides acceptance from its own occupancy.
   task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d);
      bit wa, ra;
      @(negedge clk);
      bus.i_wren   = wr;
      bus.i_rden   = rd;
      bus.i_wrdata = d;
      wa = wr && (model_q.size() < DEP);
      ra = rd && (model_q.size() > 0);
      if (ra) exp_q.push_back(model_q.pop_front());
      if (wa) model_q.push_back(d);
      @(posedge clk);
      #1;
      check_flags();
   endtask

   task automatic do_reset(input logic wr);
      @(negedge clk);
      reset        = 1'b1;
      bus.i_wren   = wr;
      bus.i_rden   = 1'b0;
      bus.i_wrdata = 128'hBAD;
      model_q.delete();
      @(posedge clk);
      #1;
      check_flags();
      chk("cnt_after_reset",    DW'(dut.cnt_q),    '0);
      chk("wr_ptr_after_reset", DW'(dut.wr_ptr_q), '0);
      chk("rd_ptr_after_reset", DW'(dut.rd_ptr_q), '0);
      @(negedge clk);
      reset      = 1'b0;
      bus.i_wren = 1'b0;
   endtask

   // Monitor: whenever the DUT accepts a read, pop the expected value one cycle later.
   always @(posedge clk) begin : monitor
      bit fire;
      bit rst;
      rst  = reset;
      fire = !reset && bus.i_rden && !bus.o_empty;
      #1;
      if (rst) begin
         last_rd = '0;
         chk("rddata_reset", bus.o_rddata, '0);
      end else if (fire) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_read: got 0x%0h, expected no read", bus.o_rddata);
         end else begin
            last_rd = exp_q.pop_front();
            chk("rddata", bus.o_rddata, last_rd);
         end
      end else begin
         chk("rddata_hold", bus.o_rddata, last_rd);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_wren   = 1'b0;
      bus.i_rden   = 1'b0;
      bus.i_wrdata = '0;
      repeat (2) @(posedge clk);
      do_reset(1'b0);

      // Reads while empty are dropped.
      repeat (3) step(1'b0, 1'b1, '0);
      chk("cnt_empty_reads", DW'(dut.cnt_q), '0);

      // Fill with 0x1..0x10.
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 1'b0, DW'(i));
         if (i == 1)  chk("empty_after_1st", DW'(bus.o_empty), '0);
         if (i == 13) chk("alm_full_at_13", DW'(bus.o_alm_full), '0);
         if (i == 14) chk("alm_full_at_14", DW'(bus.o_alm_full), DW'(1));
         if (i == 15) chk("full_at_15", DW'(bus.o_full), '0);
         if (i == 16) chk("full_at_16", DW'(bus.o_full), DW'(1));
      end

      // Write while full is dropped, then drain.
      step(1'b1, 1'b0, 128'hDEAD);
      chk("cnt_full_drop", DW'(dut.cnt_q), DW'(16));
      repeat (16) step(1'b0, 1'b1, '0);
      chk("cnt_drained", DW'(dut.cnt_q), '0);

      // Empty with simultaneous write/read: only the write lands.
      step(1'b1, 1'b1, 128'hAA);
      chk("empty_wr_rd_empty", DW'(bus.o_empty), '0);
      chk("empty_wr_rd_hold", bus.o_rddata, DW'(16));
      step(1'b0, 1'b1, '0);

      // Steady occupancy of 5 across pointer wraps.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(256 + i));
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, DW'(512 + i));
      chk("cnt_steady_5", DW'(dut.cnt_q), DW'(5));
      repeat (5) step(1'b0, 1'b1, '0);

      // Reset mid-operation with a write pending.
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, DW'(768 + i));
      do_reset(1'b1);
      chk("reset_empty",     DW'(bus.o_empty),     DW'(1));
      chk("reset_alm_empty", DW'(bus.o_alm_empty), DW'(1));
      step(1'b1, 1'b0, 128'h55);
      chk("first_write_addr0", dut.u_mem.mem_q[0], 128'h55);
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);

      chk("scoreboard_drained", DW'(exp_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_128.md
SYNC_FIFO_128 -- requirements
Module: sync_fifo_128

Interface
REQ-001 Parameter DATA_W, default 128: width of write and read data.
REQ-002 Parameter DEPTH, default 16: number of entries; power of two, at least 4.
REQ-003 Parameter AF_THR, default DEPTH-2: occupancy at or above which o_alm_full asserts.
REQ-004 Parameter AE_THR, default 2: occupancy at or below which o_alm_empty asserts.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 i_wren  input  1  write request; i_wrdata is sampled with it.
REQ-008 i_rden  input  1  read request.
REQ-009 i_wrdata  input  DATA_W  write data.
REQ-010 o_full  output  1  occupancy equals DEPTH.
REQ-011 o_alm_full  output  1  occupancy is at or above AF_THR.
REQ-012 o_empty  output  1  occupancy equals 0.
REQ-013 o_alm_empty  output  1  occupancy is at or below AE_THR.
REQ-014 o_rddata  output  DATA_W  registered read data.

Function
REQ-015 A write is accepted when i_wren=1 and o_full=0 at the rising edge: i_wrdata is stored at the write pointer, and the write pointer increments.
REQ-016 A read is accepted when i_rden=1 and o_empty=0 at the rising edge: the entry at the read pointer is loaded into o_rddata at that same edge, and the read pointer increments.
REQ-017 Read latency is 1: data is visible on o_rddata in the cycle after the request cycle.
REQ-018 o_rddata holds its last value when no read is accepted.
REQ-019 A write while full is dropped with no change to state or memory; a read while empty is dropped and o_rddata is unchanged.
REQ-020 Simultaneous accepted read and write: both proceed and occupancy is unchanged.
REQ-021 When empty, a simultaneous write and read accepts only the write; there is no fall-through.
REQ-022 When full, a simultaneous write and read accepts only the read; the write is dropped.
REQ-023 Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no special handling.
REQ-024 Occupancy is a log2(DEPTH)+1 bit counter: +1 on write-only, -1 on read-only, unchanged otherwise.
REQ-025 All four flags are decoded from the registered occupancy only, so they reflect the state after the previous edge and are never a function of the current i_wren or i_rden.
REQ-026 Data is strictly first-in, first-out, with no loss and no duplication across any number of wraps.

Reset
REQ-027 While reset=1 at an edge: pointers=0, occupancy=0, o_rddata=0, o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0.
REQ-028 Reset overrides any simultaneous i_wren or i_rden.
REQ-029 Reset asserted mid-operation discards all entries; memory contents need not be cleared.
REQ-030 The first write accepted after reset deasserts is stored at address 0.

Structure
REQ-031 Package fifo_pkg holds DATA_W, DEPTH and the threshold defaults, and derived constants PTR_W=$clog2(DEPTH) and CNT_W=PTR_W+1.
REQ-032 Storage is a separate sub-module fifo_mem_2p: a simple dual-port memory with one synchronous write port and one synchronous registered read port, and no reset on the array.
REQ-033 Pointer, counter and flag logic reside in sync_fifo_128.
REQ-034 The block connects one-to-one to the existing FIFO interface signals.

Verification
REQ-035 Reset, then 16 writes of values 0x1..0x10 -> o_full=1 after the 16th edge; o_alm_full=1 from the 14th edge; o_empty deasserts after the 1st edge.
REQ-036 From full, a write of 0xDEAD -> dropped; then 16 reads -> o_rddata sequence 0x1..0x10 each one cycle after its read, and no 0xDEAD appears.
REQ-037 Read while empty after reset -> o_rddata stays 0 and occupancy stays 0.
REQ-038 With occupancy 5, simultaneous write and read for 40 cycles -> occupancy stays 5; FIFO order holds across pointer wrap.
REQ-039 Empty, simultaneous write 0xAA and read -> only the write is accepted; o_empty=0 next cycle; o_rddata unchanged.
REQ-040 Reset asserted after 9 writes, together with i_wren=1 -> o_empty=1 and o_alm_empty=1 next cycle; next accepted write lands at address 0 and reads back correctly.
